// File: rtl/lfsr_5bit.sv
// Free-running maximal-length Fibonacci LFSR with a built-in primitive tap table,
// all-zero lockup recovery and a combinational sequence-wrap flag.
module lfsr_5bit #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter logic [WIDTH-1:0] TAPS  = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q,
    output logic             serial_out,
    output logic             wrap
);

    // Tap masks: bit n-1 set for each 1-based tap position n of the primitive polynomial.
    function automatic logic [15:0] table_taps(input int w);
        case (w)
            3:       table_taps = 16'h0006;
            4:       table_taps = 16'h000C;
            5:       table_taps = 16'h0014;
            6:       table_taps = 16'h0030;
            7:       table_taps = 16'h0060;
            8:       table_taps = 16'h00B8;
            9:       table_taps = 16'h0110;
            10:      table_taps = 16'h0240;
            11:      table_taps = 16'h0500;
            12:      table_taps = 16'h0829;
            13:      table_taps = 16'h100D;
            14:      table_taps = 16'h2015;
            15:      table_taps = 16'h6000;
            16:      table_taps = 16'hD008;
            default: table_taps = 16'h0000;
        endcase
    endfunction

    localparam int               TW         = (WIDTH > 16) ? WIDTH : 16;
    localparam logic [TW-1:0]    TABLE_MASK = TW'(table_taps(WIDTH));
    localparam logic [WIDTH-1:0] TAP_MASK   = (TAPS != '0) ? TAPS : TABLE_MASK[WIDTH-1:0];

    generate
        if (TAPS == '0 && (WIDTH < 3 || WIDTH > 16)) begin : g_width_check
            $error("lfsr_5bit: WIDTH must be 3..16 when the built-in tap table is used");
        end
    endgenerate

    logic             fb;
    logic [WIDTH-1:0] q_next;

    always_comb begin
        fb = ^(q & TAP_MASK);
        // The all-zero state is a fixed point of the shift; kick it back into the sequence.
        if (q == '0) begin
            q_next = WIDTH'(1);
        end else begin
            q_next = {q[WIDTH-2:0], fb};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= SEED;
        end else begin
            q <= q_next;
        end
    end

    assign serial_out = q[WIDTH-1];
    assign wrap       = (q == SEED);

endmodule

// File: tb/tb_lfsr_5bit.sv
// Directed self-checking bench for lfsr_5bit: reset, sequence, period, mid-run reset,
// zero-seed lockup recovery and period sweep at WIDTH 8 and 16.
module tb_lfsr_5bit;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        reset_a, reset_b, reset_c;

    logic [4:0]  q_a, q_z;
    logic        ser_a, ser_z, wrap_a, wrap_z;
    logic [7:0]  q8;
    logic [15:0] q16;
    logic        ser8, ser16, wrap8, wrap16;

    int checks   = 0;
    int failures = 0;

    // Hand-derived sequence from seed 00001 with fb = q[4]^q[2]
    logic [4:0] exp_seq [0:8] = '{5'b00010, 5'b00100, 5'b01001, 5'b10010, 5'b00101,
                                  5'b01011, 5'b10110, 5'b01100, 5'b11001};

    always #5 if (clk_en) clk = ~clk;

    lfsr_5bit dut (.clk(clk), .reset(reset_a), .q(q_a), .serial_out(ser_a), .wrap(wrap_a));
    lfsr_5bit #(.SEED(5'b00000)) dut_z (.clk(clk), .reset(reset_b), .q(q_z), .serial_out(ser_z), .wrap(wrap_z));
    lfsr_5bit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset_c), .q(q8),  .serial_out(ser8),  .wrap(wrap8));
    lfsr_5bit #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset_c), .q(q16), .serial_out(ser16), .wrap(wrap16));

    task automatic test_reset();
        reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
        #2;
        reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
        #6;
        // No clock edge has occurred yet: reset must have acted asynchronously.
        checks++; if (q_a !== 5'b00001) begin failures++; $display("FAIL reset_q: got %b expected 00001", q_a); end
        checks++; if (wrap_a !== 1'b1) begin failures++; $display("FAIL reset_wrap: got %b expected 1", wrap_a); end
        checks++; if (ser_a !== 1'b0) begin failures++; $display("FAIL reset_serial: got %b expected 0", ser_a); end
        checks++; if (q_z !== 5'b00000) begin failures++; $display("FAIL reset_q_seed0: got %b expected 00000", q_z); end
        checks++; if (wrap_z !== 1'b1) begin failures++; $display("FAIL reset_wrap_seed0: got %b expected 1", wrap_z); end
        checks++; if (q8 !== 8'h01) begin failures++; $display("FAIL reset_q8: got %h expected 01", q8); end
        checks++; if (q16 !== 16'h0001) begin failures++; $display("FAIL reset_q16: got %h expected 0001", q16); end
        clk_en  = 1'b1;
        reset_a = 1'b1;
    endtask

    task automatic test_sequence();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checks++;
            if (q_a !== exp_seq[i]) begin
                failures++; $display("FAIL seq_step%0d: got %b expected %b", i + 1, q_a, exp_seq[i]);
            end
            checks++;
            if (ser_a !== exp_seq[i][4]) begin
                failures++; $display("FAIL seq_serial%0d: got %b expected %b", i + 1, ser_a, exp_seq[i][4]);
            end
        end
    endtask

    task automatic test_period();
        logic [4:0]  model;
        logic [31:0] seen;
        int          distinct;
        seen = '0; distinct = 0; model = 5'b00001;
        @(negedge clk);
        reset_a = 1'b0;
        #1;
        reset_a = 1'b1;
        for (int n = 1; n <= 31; n++) begin
            @(negedge clk);
            model = {model[3:0], model[4] ^ model[2]};
            checks++;
            if (q_a !== model) begin failures++; $display("FAIL period_model_c%0d: got %b expected %b", n, q_a, model); end
            checks++;
            if (q_a === 5'b00000) begin failures++; $display("FAIL period_zero_c%0d: got %b expected nonzero", n, q_a); end
            checks++;
            if (wrap_a !== (n == 31)) begin failures++; $display("FAIL period_wrap_c%0d: got %b expected %b", n, wrap_a, (n == 31)); end
            if (!$isunknown(q_a) && !seen[q_a]) begin seen[q_a] = 1'b1; distinct++; end
        end
        checks++;
        if (q_a !== 5'b00001) begin failures++; $display("FAIL period_end_q: got %b expected 00001", q_a); end
        checks++;
        if (distinct != 31) begin failures++; $display("FAIL period_distinct: got %0d expected 31", distinct); end
    endtask

    task automatic test_midrun_reset();
        for (int i = 0; i < 7; i++) @(negedge clk);
        checks++;
        if (q_a !== exp_seq[6]) begin failures++; $display("FAIL mid_before: got %b expected %b", q_a, exp_seq[6]); end
        #2;
        reset_a = 1'b0;
        #1;
        checks++;
        if (q_a !== 5'b00001) begin failures++; $display("FAIL mid_async_q: got %b expected 00001", q_a); end
        checks++;
        if (wrap_a !== 1'b1) begin failures++; $display("FAIL mid_async_wrap: got %b expected 1", wrap_a); end
        @(negedge clk);
        reset_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (q_a !== exp_seq[i]) begin failures++; $display("FAIL mid_restart%0d: got %b expected %b", i + 1, q_a, exp_seq[i]); end
        end
    endtask

    task automatic test_lockup();
        logic [4:0] exp_lock [0:3];
        exp_lock = '{5'b00001, 5'b00010, 5'b00100, 5'b01001};
        @(negedge clk);
        reset_b = 1'b1;
        #1;
        checks++;
        if (wrap_z !== 1'b1) begin failures++; $display("FAIL lock_wrap_pre: got %b expected 1", wrap_z); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (q_z !== exp_lock[i]) begin failures++; $display("FAIL lock_step%0d: got %b expected %b", i + 1, q_z, exp_lock[i]); end
        end
        checks++;
        if (wrap_z !== 1'b0) begin failures++; $display("FAIL lock_wrap_post: got %b expected 0", wrap_z); end
    endtask

    task automatic test_width_sweep();
        logic [255:0] seen8;
        int           distinct8, per8, per16;
        bit           zero8, zero16, wrap8_ok;
        seen8 = '0; distinct8 = 0; per8 = 0; per16 = 0;
        zero8 = 1'b0; zero16 = 1'b0; wrap8_ok = 1'b0;
        @(negedge clk);
        reset_c = 1'b1;
        for (int n = 1; n <= 65536; n++) begin
            @(negedge clk);
            if (per8 == 0) begin
                if (q8 === 8'h00) zero8 = 1'b1;
                if (!$isunknown(q8) && !seen8[q8]) begin seen8[q8] = 1'b1; distinct8++; end
                if (q8 === 8'h01) begin per8 = n; wrap8_ok = (wrap8 === 1'b1); end
            end
            if (q16 === 16'h0000) zero16 = 1'b1;
            if (q16 === 16'h0001) begin per16 = n; break; end
        end
        checks++; if (per8 != 255) begin failures++; $display("FAIL w8_period: got %0d expected 255", per8); end
        checks++; if (distinct8 != 255) begin failures++; $display("FAIL w8_distinct: got %0d expected 255", distinct8); end
        checks++; if (zero8) begin failures++; $display("FAIL w8_zero: got 1 expected 0"); end
        checks++; if (!wrap8_ok) begin failures++; $display("FAIL w8_wrap: got 0 expected 1"); end
        checks++; if (per16 != 65535) begin failures++; $display("FAIL w16_period: got %0d expected 65535", per16); end
        checks++; if (zero16) begin failures++; $display("FAIL w16_zero: got 1 expected 0"); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_period();
        test_midrun_reset();
        test_lockup();
        test_width_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
